// File: rtl/song_pkg.sv
// Shared types and default sizing for the song sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package song_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } seq_state_t;

  localparam int SONG_LEN_DEF = 90;
  localparam int LANES_DEF    = 4;
  localparam int BEAT_DIV_DEF = 25000000;

endpackage

// File: rtl/song_note_rom.sv
// Note-lane pattern ROM: maps a beat index to the lanes that carry a note.
// Latency: combinational.
// Backpressure: none; indices at or beyond SONG_LEN return an empty pattern.
module song_note_rom
  import song_pkg::*;
#(
  parameter int SONG_LEN = SONG_LEN_DEF,
  parameter int LANES    = LANES_DEF
) (
  input  logic [7:0]       idx,
  output logic [LANES-1:0] lanes
);

  localparam logic [8:0] LEN9 = 9'(SONG_LEN);

  logic [3:0] pat;

  // 16-entry base pattern repeated across the song, spread over however many lanes exist
  always_comb begin
    pat   = 4'b0000;
    lanes = '0;
    case (idx[3:0])
      4'd0:  pat = 4'b0001;
      4'd1:  pat = 4'b0010;
      4'd2:  pat = 4'b0100;
      4'd3:  pat = 4'b1000;
      4'd4:  pat = 4'b0011;
      4'd5:  pat = 4'b0110;
      4'd6:  pat = 4'b1100;
      4'd7:  pat = 4'b1001;
      4'd8:  pat = 4'b0101;
      4'd9:  pat = 4'b1010;
      4'd10: pat = 4'b0001;
      4'd11: pat = 4'b1000;
      4'd12: pat = 4'b0010;
      4'd13: pat = 4'b0100;
      4'd14: pat = 4'b1111;
      default: pat = 4'b0000;
    endcase
    if ({1'b0, idx} < LEN9) begin
      for (int i = 0; i < LANES; i++) begin
        lanes[i] = pat[i % 4];
      end
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song position sequencer: beat prescaler, play/pause/restart FSM, lane pattern.
// Latency: all outputs registered; first beat BEAT_DIV cycles after start.
// Backpressure: none; pause freezes the divider. Loop build: SONG_SEQUENCER_LOOP_EN.
module song_sequencer
  import song_pkg::*;
#(
  parameter int BEAT_DIV = BEAT_DIV_DEF,
  parameter int SONG_LEN = SONG_LEN_DEF,
  parameter int LANES    = LANES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             restart,
  output logic [7:0]       counter,
  output logic             beat,
  output logic             playing,
  output logic             done,
  output logic [LANES-1:0] note_lanes
);

  localparam int               DIV_W    = $clog2(BEAT_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEAT_DIV - 1);
  localparam logic [7:0]       CNT_LAST = 8'(SONG_LEN - 1);

  seq_state_t       state_q, state_d;
  logic [7:0]       counter_q, counter_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             beat_q, beat_d;
  logic             playing_q, playing_d;
  logic             done_q, done_d;
  logic [LANES-1:0] lanes_q, lanes_d;
  logic [LANES-1:0] rom_lanes;

  // Look up the pattern for the beat index that will be visible next cycle,
  // so note_lanes lines up with counter.
  song_note_rom #(
    .SONG_LEN (SONG_LEN),
    .LANES    (LANES)
  ) u_rom (
    .idx   (counter_d),
    .lanes (rom_lanes)
  );

  // Next-state: restart overrides everything; pause freezes the divider;
  // a PAUSED cycle with pause released already counts as a playing cycle.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    div_d     = div_q;
    beat_d    = 1'b0;
    if (restart) begin
      state_d   = PLAYING;
      counter_d = '0;
      div_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          counter_d = '0;
          div_d     = '0;
          if (start) begin
            state_d = PLAYING;
          end
        end
        PLAYING, PAUSED: begin
          if (pause) begin
            state_d = PAUSED;
          end else begin
            state_d = PLAYING;
            if (div_q == DIV_LAST) begin
              div_d  = '0;
              beat_d = 1'b1;
              if (counter_q < CNT_LAST) begin
                counter_d = counter_q + 8'd1;
              end else begin
`ifdef SONG_SEQUENCER_LOOP_EN
                counter_d = '0;
`else
                state_d = DONE;
`endif
              end
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
        end
        default: begin
          // DONE: everything holds until restart or reset
        end
      endcase
    end
    playing_d = (state_d == PLAYING) || (state_d == PAUSED);
    done_d    = (state_d == DONE);
    lanes_d   = playing_d ? rom_lanes : '0;
  end

  // State and registered outputs, synchronous reset abandons the song at once
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= '0;
      div_q     <= '0;
      beat_q    <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
      lanes_q   <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      div_q     <= div_d;
      beat_q    <= beat_d;
      playing_q <= playing_d;
      done_q    <= done_d;
      lanes_q   <= lanes_d;
    end
  end

  assign counter    = counter_q;
  assign beat       = beat_q;
  assign playing    = playing_q;
  assign done       = done_q;
  assign note_lanes = lanes_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer with a short song (BEAT_DIV=4, SONG_LEN=12).
// Latency: n/a.
// Backpressure: n/a.
module tb_song_sequencer;

  localparam int BD = 4;
  localparam int SL = 12;
  localparam int LN = 4;

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          start   = 1'b0;
  logic          pause   = 1'b0;
  logic          restart = 1'b0;
  logic [7:0]    counter;
  logic          beat;
  logic          playing;
  logic          done;
  logic [LN-1:0] note_lanes;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  song_sequencer #(
    .BEAT_DIV (BD),
    .SONG_LEN (SL),
    .LANES    (LN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .restart    (restart),
    .counter    (counter),
    .beat       (beat),
    .playing    (playing),
    .done       (done),
    .note_lanes (note_lanes)
  );

  // Song-level model: mode, elapsed ticks within the current beat, beat index
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_END  = 3;

  int m_mode  = M_IDLE;
  int m_cnt   = 0;
  int m_phase = 0;
  int m_beat  = 0;
  int rom_tbl [16] = '{1, 2, 4, 8, 3, 6, 12, 9, 5, 10, 1, 8, 2, 4, 15, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance the model on every edge, then compare all outputs just after it
  always begin
    int exp_play;
    int exp_lanes;
    @(posedge clk);
    if (reset) begin
      m_mode = M_IDLE; m_cnt = 0; m_phase = 0; m_beat = 0;
    end else if (restart) begin
      m_mode = M_RUN; m_cnt = 0; m_phase = 0; m_beat = 0;
    end else begin
      m_beat = 0;
      case (m_mode)
        M_IDLE: if (start) begin m_mode = M_RUN; m_phase = 0; end
        M_RUN, M_HOLD: begin
          if (pause) begin
            m_mode = M_HOLD;
          end else begin
            m_mode = M_RUN;
            m_phase++;
            if (m_phase == BD) begin
              m_phase = 0;
              m_beat  = 1;
              if (m_cnt == SL - 1) begin
`ifdef SONG_SEQUENCER_LOOP_EN
                m_cnt = 0;
`else
                m_mode = M_END;
`endif
              end else begin
                m_cnt++;
              end
            end
          end
        end
        default: ;
      endcase
    end
    #1;
    exp_play  = (m_mode == M_RUN || m_mode == M_HOLD) ? 1 : 0;
    exp_lanes = (exp_play == 1 && m_cnt < SL) ? rom_tbl[m_cnt % 16] : 0;
    check("m_counter", 32'(counter), m_cnt);
    check("m_beat", 32'(beat), m_beat);
    check("m_playing", 32'(playing), exp_play);
    check("m_done", 32'(done), (m_mode == M_END) ? 1 : 0);
    check("m_lanes", 32'(note_lanes), exp_lanes);
  end

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; restart = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_counter", 32'(counter), 0);
    check("rst_beat", 32'(beat), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_done", 32'(done), 0);
    check("rst_lanes", 32'(note_lanes), 0);
    tick();
    check("idle_counter", 32'(counter), 0);
    pause = 1'b1; tick(); tick();
    check("idle_pause_ignored", 32'(playing), 0);
    pause = 1'b0;

    // Start: first beat 4 cycles after the sampling edge
    start = 1'b1; tick(); start = 1'b0;
    check("start_playing", 32'(playing), 1);
    check("start_counter", 32'(counter), 0);
    repeat (3) tick();
    check("pre_beat_counter", 32'(counter), 0);
    check("pre_beat_beat", 32'(beat), 0);
    tick();
    check("beat1_counter", 32'(counter), 1);
    check("beat1_beat", 32'(beat), 1);
    check("beat1_lanes", 32'(note_lanes), 2);
    tick();
    check("beat1_width", 32'(beat), 0);
    repeat (3) tick();
    check("beat2_counter", 32'(counter), 2);
    check("beat2_beat", 32'(beat), 1);

    // Pause sampled at cycles 6..15
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    pause = 1'b1; tick();
    check("pause_counter_a", 32'(counter), 1);
    check("pause_playing", 32'(playing), 1);
    repeat (9) tick();
    check("pause_counter_b", 32'(counter), 1);
    pause = 1'b0;
    tick(); tick();
    check("resume_counter_a", 32'(counter), 1);
    tick();
    check("resume_counter_b", 32'(counter), 2);
    check("resume_beat", 32'(beat), 1);

    // End of song
    for (int i = 0; i < 200; i++) begin
      if (counter == 8'd11) break;
      tick();
    end
    check("reach_last", 32'(counter), 11);
    repeat (BD) tick();
`ifdef SONG_SEQUENCER_LOOP_EN
    check("loop_counter", 32'(counter), 0);
    check("loop_beat", 32'(beat), 1);
    check("loop_done", 32'(done), 0);
    check("loop_playing", 32'(playing), 1);
    check("loop_lanes", 32'(note_lanes), 1);
`else
    check("end_done", 32'(done), 1);
    check("end_playing", 32'(playing), 0);
    check("end_counter", 32'(counter), 11);
    check("end_lanes", 32'(note_lanes), 0);
`endif
    start = 1'b1; tick(); start = 1'b0; tick();
`ifdef SONG_SEQUENCER_LOOP_EN
    check("late_start_counter", 32'(counter), 0);
`else
    check("late_start_counter", 32'(counter), 11);
    check("late_start_done", 32'(done), 1);
`endif

    // Restart from the end state, then restart colliding with a beat edge
    restart = 1'b1; tick(); restart = 1'b0;
    check("restart_counter", 32'(counter), 0);
    check("restart_playing", 32'(playing), 1);
    check("restart_done", 32'(done), 0);
    repeat (23) tick();
    check("pre_collide_counter", 32'(counter), 5);
    restart = 1'b1; tick(); restart = 1'b0;
    check("collide_counter", 32'(counter), 0);
    check("collide_beat", 32'(beat), 0);
    repeat (4) tick();
    check("after_collide_counter", 32'(counter), 1);

    // start and pause together in IDLE
    do_reset();
    start = 1'b1; pause = 1'b1; tick(); start = 1'b0;
    check("sp_playing", 32'(playing), 1);
    repeat (6) tick();
    check("sp_held_counter", 32'(counter), 0);
    pause = 1'b0;
    repeat (6) tick();

    // Reset mid-song abandons playback
    reset = 1'b1; tick();
    check("midrst_counter", 32'(counter), 0);
    check("midrst_playing", 32'(playing), 0);
    reset = 1'b0; tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Generates the song position counter consumed by the progress-bar logic.
- Beat prescaler advances an 8-bit note index through a fixed-length song.
- Play/pause/restart control, done flag, and per-beat note-lane pattern for the note-falling/scoring logic.
- Sits between board buttons/game FSM and the display/scoring blocks.

Parameters:
- BEAT_DIV, 25000000: clk cycles per beat (0.5 s at 50 MHz); must be >= 2.
- SONG_LEN, 90: number of beats; valid counter range 0..SONG_LEN-1; must be <= 256.
- LANES, 4: note lanes per beat.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin playback from IDLE; sampled each clk
- pause  in  1  level; hold playback while high
- restart  in  1  restart song from beat 0, any state
- counter  out  8  current beat index, registered
- beat  out  1  one-cycle pulse on each counter advance
- playing  out  1  high in PLAYING or PAUSED
- done  out  1  high in DONE
- note_lanes  out  LANES  lane pattern for current beat, registered

Behaviour:
- States: IDLE, PLAYING, PAUSED, DONE.
- Reset:
  - State goes to IDLE.
  - counter, beat, playing, done and note_lanes go to 0; divider goes to 0.
  - Reset mid-song abandons the song immediately.
- Input priority: reset > restart > pause > start.
- IDLE:
  - counter held at 0.
  - start=1 moves to PLAYING with divider=0.
  - pause alone is ignored.
- PLAYING:
  - Divider counts 0..BEAT_DIV-1.
  - When divider==BEAT_DIV-1, at that edge: divider<=0 and beat<=1. If counter<SONG_LEN-1, counter<=counter+1. If counter==SONG_LEN-1, the state goes to DONE and counter holds.
  - beat is 0 on every other cycle.
  - First advance: counter=1 and beat=1 become visible BEAT_DIV cycles after the edge that sampled start.
- PAUSED:
  - Entered when pause=1 is sampled in PLAYING.
  - Divider and counter frozen; beat=0.
  - pause=0 returns to PLAYING and the divider resumes from its frozen value, so no beat time is lost.
- DONE:
  - counter holds SONG_LEN-1; done=1; playing=0; beat=0.
  - start and pause ignored.
- restart=1 in any non-reset state:
  - counter<=0, divider<=0, beat<=0, state<=PLAYING.
  - A restart that coincides with a beat edge wins; no beat is emitted.
- start and pause both high in IDLE: start wins, the state goes to PLAYING; the next cycle goes to PAUSED if pause is still high.
- start while PLAYING or PAUSED is ignored.
- note_lanes:
  - Registered lookup of the ROM at the next counter value.
  - Aligned cycle-for-cycle with counter.
  - Forced to 0 in IDLE and DONE.
- Widths:
  - Divider is $clog2(BEAT_DIV) bits.
  - counter compare is zero-extended to 8 bits.
  - No arithmetic wrap is possible without the optional feature.

Optional Feature:
- Macro: SONG_SEQUENCER_LOOP_EN.
- Defined:
  - At the beat edge with counter==SONG_LEN-1, counter wraps to 0 and beat=1.
  - State stays PLAYING; DONE is unreachable; done stays 0.
  - Playback loops until restart or reset.
- Undefined: the end-of-song behaviour is as in Behaviour (DONE, counter held).

Decomposition:
- Shared package song_pkg holds:
  - enum seq_state_t {IDLE, PLAYING, PAUSED, DONE}
  - SONG_LEN_DEF=90
  - LANES_DEF=4
  - BEAT_DIV_DEF=25000000
- One sub-module, song_note_rom: combinational case ROM mapping an 8-bit beat index to a LANES-bit pattern; indices >= SONG_LEN return 0.

Test Plan (BEAT_DIV=4, SONG_LEN=12):
- Reset: reset=1 for 2 cycles, then 0 -> counter=0, beat=0, playing=0, done=0, note_lanes=0.
- Start: start pulse at cycle 0 -> counter=1 with beat=1 at cycle 4, counter=2 at cycle 8, and beat pulses exactly one cycle wide.
- Pause: start, then pause=1 from cycle 6 to 15 -> counter stays 1 throughout; after release, counter=2 arrives 2 cycles later (divider resumed).
- End of song: run to the end -> counter reaches 11, next beat edge gives done=1, playing=0, counter=11 held; a later start pulse causes no change.
- Restart: restart in DONE -> next cycle counter=0, playing=1, done=0; also restart asserted on a beat edge at counter=5 -> counter=0, beat=0.
- Loop (SONG_SEQUENCER_LOOP_EN defined): at counter=11 the beat edge gives counter=0, beat=1, done stays 0, playing stays 1; note_lanes matches ROM[0].
